// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C transaction sequencer: FSM states, command record, timer width.
package i2c_seq_pkg;

  localparam int unsigned CMD_ADDR_W = 8;
  localparam int unsigned CMD_DATA_W = 24;
  // Must hold TIMEOUT_CYC-1 for the largest supported TIMEOUT_CYC (65535).
  localparam int unsigned TIMER_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACT,
    WAIT_STOP
  } i2c_seq_state_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// Host command/response and controller-facing signals of the transaction sequencer.
interface i2c_txn_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 24
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_nack;
  logic              rsp_timeout;
  logic              busy;
  logic              ctrl_start;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [DATA_W-1:0] ctrl_data_snt;
  logic              ctrl_scl;
  logic              ctrl_sda;
  logic              ctrl_ack;
  logic [DATA_W-1:0] ctrl_data_rcv;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, rsp_ready,
    input  ctrl_scl, ctrl_sda, ctrl_ack, ctrl_data_rcv,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_timeout, busy,
    output ctrl_start, ctrl_addr, ctrl_data_snt
  );

  // Host / controller side
  modport master (
    output cmd_valid, cmd_addr, cmd_data, rsp_ready,
    output ctrl_scl, ctrl_sda, ctrl_ack, ctrl_data_rcv,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_timeout, busy,
    input  ctrl_start, ctrl_addr, ctrl_data_snt
  );

endinterface

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with a registered ready (= !full) flag.
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  i2c_cmd_t i_cmd,
  input  logic     i_pop,
  output i2c_cmd_t o_head,
  output logic     o_ready,
  output logic     o_empty,
  output logic     o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  i2c_cmd_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_ready;
  logic [PTR_W:0]   w_count_d;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  // Gate on the registered ready: a pop in the same cycle never frees a slot early,
  // and nothing is accepted in the first cycle after reset.
  assign w_push  = i_push && r_ready;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_ready = r_ready;

  // Occupancy next state
  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - 1'b1;
    end
  end

  // Pointers, count and ready flag; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_d;
      r_ready <= (w_count_d != (PTR_W+1)'(DEPTH));
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_cmd;
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Launches buffered host commands on the I2C controller one at a time and returns one
// response per command (captured data/ack at STOP, or a timeout abort).
module i2c_txn_sequencer
  import i2c_seq_pkg::*;
#(
  // ADDR_W/DATA_W must match the i2c_cmd_t field widths.
  parameter int unsigned ADDR_W      = CMD_ADDR_W,
  parameter int unsigned DATA_W      = CMD_DATA_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned START_HOLD  = 2,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input logic                clk,
  input logic                rst,
  i2c_txn_sequencer_if.slave bus
);

  localparam int unsigned HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(START_HOLD - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  i2c_seq_state_t    r_state, w_state_d;
  logic              r_start, w_start_d;
  logic [HOLD_W-1:0] r_hold, w_hold_d;
  logic [TIMER_W-1:0] r_timer, w_timer_d;
  logic [ADDR_W-1:0] r_caddr, w_caddr_d;
  logic [DATA_W-1:0] r_cdata, w_cdata_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_d;
  logic              r_rsp_nack, w_rsp_nack_d;
  logic              r_rsp_to, w_rsp_to_d;
  logic              r_scl_q, r_sda_q;

  i2c_cmd_t w_cmd_in;
  i2c_cmd_t w_head;
  logic     w_ready, w_empty, w_full, w_pop, w_stop;

  assign w_cmd_in.addr = bus.cmd_addr;
  assign w_cmd_in.data = bus.cmd_data;

  i2c_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.cmd_valid),
    .i_cmd   (w_cmd_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_ready (w_ready),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // STOP: SDA rises while SCL stays high across the registered and current samples
  assign w_stop = r_scl_q && !r_sda_q && bus.ctrl_scl && bus.ctrl_sda;

  // Next-state for FSM, launch outputs, timer and response register
  always_comb begin
    w_state_d     = r_state;
    w_start_d     = r_start;
    w_hold_d      = r_hold;
    w_timer_d     = r_timer;
    w_caddr_d     = r_caddr;
    w_cdata_d     = r_cdata;
    w_rsp_valid_d = r_rsp_valid;
    w_rsp_data_d  = r_rsp_data;
    w_rsp_nack_d  = r_rsp_nack;
    w_rsp_to_d    = r_rsp_to;
    w_pop         = 1'b0;

    if (r_rsp_valid && bus.rsp_ready) begin
      w_rsp_valid_d = 1'b0;
      w_rsp_data_d  = '0;
      w_rsp_nack_d  = 1'b0;
      w_rsp_to_d    = 1'b0;
    end

    unique case (r_state)
      IDLE: begin
        // Only one transaction outstanding: wait for the host to take the response
        if (!w_empty && !r_rsp_valid) begin
          w_pop     = 1'b1;
          w_caddr_d = w_head.addr;
          w_cdata_d = w_head.data;
          w_timer_d = '0;
          w_hold_d  = '0;
          w_start_d = 1'b1;
          w_state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (r_hold == HOLD_LAST) begin
          w_start_d = 1'b0;
          w_state_d = WAIT_ACT;
        end else begin
          w_hold_d = r_hold + 1'b1;
        end
      end
      WAIT_ACT: begin
        if (!bus.ctrl_scl) w_state_d = WAIT_STOP;
      end
      WAIT_STOP: begin
        if (w_stop) begin
          w_rsp_valid_d = 1'b1;
          w_rsp_data_d  = bus.ctrl_data_rcv;
          w_rsp_nack_d  = bus.ctrl_ack;
          w_rsp_to_d    = 1'b0;
          w_state_d     = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase

    // Timer runs in every active state; a STOP in the same cycle takes priority
    if ((r_state != IDLE) && !((r_state == WAIT_STOP) && w_stop)) begin
      if (r_timer == TIMER_LAST) begin
        w_rsp_valid_d = 1'b1;
        w_rsp_data_d  = '0;
        w_rsp_nack_d  = 1'b0;
        w_rsp_to_d    = 1'b1;
        w_start_d     = 1'b0;
        w_state_d     = IDLE;
      end else begin
        w_timer_d = r_timer + 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_start     <= 1'b0;
      r_hold      <= '0;
      r_timer     <= '0;
      r_caddr     <= '0;
      r_cdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_nack  <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_scl_q     <= 1'b1;
      r_sda_q     <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_start     <= w_start_d;
      r_hold      <= w_hold_d;
      r_timer     <= w_timer_d;
      r_caddr     <= w_caddr_d;
      r_cdata     <= w_cdata_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_data  <= w_rsp_data_d;
      r_rsp_nack  <= w_rsp_nack_d;
      r_rsp_to    <= w_rsp_to_d;
      r_scl_q     <= bus.ctrl_scl;
      r_sda_q     <= bus.ctrl_sda;
    end
  end

  assign bus.cmd_ready     = w_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.rsp_nack      = r_rsp_nack;
  assign bus.rsp_timeout   = r_rsp_to;
  assign bus.busy          = (r_state != IDLE) || !w_empty;
  assign bus.ctrl_start    = r_start;
  assign bus.ctrl_addr     = r_caddr;
  assign bus.ctrl_data_snt = r_cdata;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench: table of directed transactions, hand-written corner sequences and
// randomized traffic checked by a transaction-level scoreboard with a controller model.
`timescale 1ns/1ps
module tb_i2c_txn_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned TO    = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_sequencer_if #(.ADDR_W(8), .DATA_W(24)) bus ();

  i2c_txn_sequencer #(
    .ADDR_W      (8),
    .DATA_W      (24),
    .FIFO_DEPTH  (DEPTH),
    .START_HOLD  (HOLD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // What the controller model does for one launched command
  typedef struct {
    logic [7:0]  addr;
    logic [23:0] data;
    logic        ack;
    logic [23:0] rcv;
    logic        stuck;
    int          nbits;
  } plan_t;

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] data;
    logic        ack;
    logic [23:0] rcv;
    logic        stuck;
    logic [23:0] e_data;
    logic        e_nack;
    logic        e_to;
  } vec_t;

  int total = 0;
  int bad   = 0;
  plan_t plan_q[$];
  int rr_mode  = 1;  // 0: hold off, 1: always ready, 2: random
  int launches = 0;
  int rsp_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic fail_note(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // rsp_ready driver
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.rsp_ready = 1'b0;
      1:       bus.rsp_ready = 1'b1;
      default: bus.rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard + controller model, evaluated away from the active edge
  int          m_count = 0;
  bit          prev_push, prev_start, prev_rv, prev_rr, in_flight, fresh, launched_now;
  int          hold_cnt, since_launch;
  plan_t       cur;
  logic [25:0] rsp_cap;
  logic [1:0]  script[$];

  always @(negedge clk) begin
    if (!rst) begin
      m_count = 0; prev_push = 0; prev_start = 0; prev_rv = 0; prev_rr = 0;
      in_flight = 0; hold_cnt = 0; fresh = 1; script.delete(); plan_q.delete();
      bus.ctrl_scl = 1'b1; bus.ctrl_sda = 1'b1; bus.ctrl_ack = 1'b0; bus.ctrl_data_rcv = '0;
    end else begin
      launched_now = 0;
      if (prev_push) m_count++;
      if (bus.ctrl_start && !prev_start) begin
        launched_now = 1;
        m_count--;
        launches++;
        chk("launch_rsp_idle", bus.rsp_valid, 0);
        if (plan_q.size() == 0) begin
          fail_note("launch_unexpected");
        end else begin
          cur = plan_q.pop_front();
          chk("launch_addr", bus.ctrl_addr, cur.addr);
          chk("launch_data", bus.ctrl_data_snt, cur.data);
          bus.ctrl_ack      = cur.ack;
          bus.ctrl_data_rcv = cur.rcv;
          if (!cur.stuck) begin
            for (int i = 0; i < 3 + int'($urandom_range(0, 3)); i++) script.push_back(2'b11);
            for (int i = 0; i < cur.nbits; i++) begin
              logic b;
              b = 1'($urandom_range(0, 1));
              script.push_back({1'b0, b});
              script.push_back({1'b1, b});
            end
            script.push_back(2'b00);
            script.push_back(2'b10);
            script.push_back(2'b11);
          end
        end
        in_flight = 1; since_launch = 0; hold_cnt = 0;
      end
      if (bus.ctrl_start) hold_cnt++;
      if (!bus.ctrl_start && prev_start) chk("start_hold", hold_cnt, HOLD);
      if (in_flight && !launched_now) begin
        since_launch++;
        chk("addr_stable", {bus.ctrl_addr, bus.ctrl_data_snt}, {cur.addr, cur.data});
      end
      if (bus.rsp_valid && !prev_rv) begin
        rsp_cnt++;
        if (!in_flight) begin
          fail_note("rsp_unexpected");
        end else begin
          chk("rsp_data", bus.rsp_data, cur.stuck ? 24'h0 : cur.rcv);
          chk("rsp_nack", bus.rsp_nack, cur.stuck ? 1'b0 : cur.ack);
          chk("rsp_timeout", bus.rsp_timeout, cur.stuck);
          if (cur.stuck) chk("timeout_latency", since_launch, TO);
        end
        in_flight = 0;
        rsp_cap = {bus.rsp_data, bus.rsp_nack, bus.rsp_timeout};
      end else if (bus.rsp_valid && prev_rv && !prev_rr) begin
        chk("rsp_stable", {bus.rsp_data, bus.rsp_nack, bus.rsp_timeout}, rsp_cap);
      end
      chk("busy", bus.busy, (m_count != 0) || in_flight);
      chk("cmd_ready", bus.cmd_ready, fresh ? 1'b0 : (m_count != DEPTH));
      fresh = 0;
      if (script.size() > 0) {bus.ctrl_scl, bus.ctrl_sda} = script.pop_front();
      else {bus.ctrl_scl, bus.ctrl_sda} = 2'b11;
      prev_push  = bus.cmd_valid && bus.cmd_ready;
      prev_start = bus.ctrl_start;
      prev_rv    = bus.rsp_valid;
      prev_rr    = bus.rsp_ready;
    end
  end

  task automatic push(input plan_t p);
    int n = 0;
    bit acc;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = p.addr;
    bus.cmd_data  = p.data;
    do begin
      acc = bus.cmd_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 500);
    bus.cmd_valid = 1'b0;
    if (acc) plan_q.push_back(p);
    else fail_note("push_stall");
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((plan_q.size() != 0 || bus.busy || bus.rsp_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n < 3000, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"}, bus.ctrl_start, 0);
    chk({tag, "_caddr"}, bus.ctrl_addr, 0);
    chk({tag, "_cdata"}, bus.ctrl_data_snt, 0);
    chk({tag, "_rv"}, bus.rsp_valid, 0);
    chk({tag, "_rdata"}, bus.rsp_data, 0);
    chk({tag, "_rnack"}, bus.rsp_nack, 0);
    chk({tag, "_rto"}, bus.rsp_timeout, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ready"}, bus.cmd_ready, 0);
  endtask

  function automatic plan_t mk(input logic [7:0] a, input logic [23:0] d, input logic ack,
                               input logic [23:0] rcv, input logic stuck, input int nb);
    plan_t p;
    p.addr = a; p.data = d; p.ack = ack; p.rcv = rcv; p.stuck = stuck; p.nbits = nb;
    return p;
  endfunction

  vec_t tbl[5];

  initial begin
    int n;
    int l0;
    int r0;
    tbl[0] = '{8'hA0, 24'h123456, 1'b0, 24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[1] = '{8'hA1, 24'h000000, 1'b0, 24'hABCDEF, 1'b0, 24'hABCDEF, 1'b0, 1'b0};
    tbl[2] = '{8'hA2, 24'h5A5A5A, 1'b1, 24'h00FF00, 1'b0, 24'h00FF00, 1'b1, 1'b0};
    tbl[3] = '{8'hA3, 24'h777777, 1'b1, 24'hFFFFFF, 1'b1, 24'h000000, 1'b0, 1'b1};
    tbl[4] = '{8'h51, 24'h0F0F0F, 1'b0, 24'h13579B, 1'b0, 24'h13579B, 1'b0, 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", bus.cmd_ready, 1);

    // Directed table: one transaction at a time from an empty, idle sequencer
    for (int i = 0; i < 5; i++) begin
      push(mk(tbl[i].addr, tbl[i].data, tbl[i].ack, tbl[i].rcv, tbl[i].stuck, 4));
      chk("latency_t1", bus.ctrl_start, 0);
      @(posedge clk); #1;
      chk("latency_t2", bus.ctrl_start, 1);
      n = 0;
      while (!bus.rsp_valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk("tbl_rsp_seen", bus.rsp_valid, 1);
      chk("tbl_rsp_data", bus.rsp_data, tbl[i].e_data);
      chk("tbl_rsp_nack", bus.rsp_nack, tbl[i].e_nack);
      chk("tbl_rsp_timeout", bus.rsp_timeout, tbl[i].e_to);
      drain("tbl_drain");
    end

    // Five back-to-back pushes: first pops at once, so the fifth fills the FIFO
    r0 = rsp_cnt;
    for (int i = 0; i < 5; i++) push(mk(8'h10 + 8'(i), 24'(i * 3 + 1), 1'b0, 24'hC0 + 24'(i), 1'b0, 2));
    chk("full_after5", bus.cmd_ready, 0);
    drain("b2b_drain");
    chk("b2b_rsp_count", rsp_cnt - r0, 5);

    // Response held off: no second launch until the handshake
    rr_mode = 0;
    l0 = launches;
    push(mk(8'h20, 24'h111111, 1'b0, 24'h222222, 1'b0, 3));
    push(mk(8'h21, 24'h333333, 1'b1, 24'h444444, 1'b0, 3));
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("hold_rsp_valid", bus.rsp_valid, 1);
    chk("hold_no_launch", launches - l0, 1);
    rr_mode = 1;
    n = 0;
    while (launches - l0 < 2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_second_launch", launches - l0, 2);
    drain("hold_drain");

    // Asynchronous reset while waiting for STOP, with commands still queued
    push(mk(8'h30, 24'hDEAD01, 1'b0, 24'h5555AA, 1'b0, 8));
    push(mk(8'h31, 24'hDEAD02, 1'b0, 24'h000001, 1'b0, 2));
    push(mk(8'h32, 24'hDEAD03, 1'b0, 24'h000002, 1'b0, 2));
    n = 0;
    while (bus.ctrl_scl && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_wait_stop", bus.ctrl_scl, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    plan_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    l0 = launches;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_no_launch", launches - l0, 0);
    chk("post_rst_ready", bus.cmd_ready, 1);

    // Randomized traffic against the scoreboard
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      push(mk(8'($urandom), 24'($urandom), 1'($urandom_range(0, 1)), 24'($urandom),
              ($urandom_range(0, 7) == 0), int'($urandom_range(1, 8))));
    end
    rr_mode = 1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
